// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds the loader FSM state encoding and the stream framing constants.
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN (adds the CHK state).
package instr_loader_pkg;

    // Bytes in the length header and bytes per instruction word.
    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;

    localparam int unsigned LEN_W  = 8 * LEN_BYTES;
    localparam int unsigned WORD_W = 8 * BYTES_PER_WORD;
    localparam int unsigned IDX_W  = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StWrite,
        StChk,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/instr_loader.sv
// Boot-time writer for the core's instruction memory.
// Accepts a byte stream (16-bit word count N, low byte first, then N little-endian
// 32-bit words), writes each word to a word-addressed memory port and keeps the
// core stalled until the whole image is written.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_start               begin a load (honoured in IDLE, DONE, ERR)
//   i_valid, i_byte       byte stream input
//   o_ready               loader accepts a byte this cycle (registered)
//   o_we, o_waddr, o_wdata instruction memory write port (one pulse per word)
//   o_cpu_hold            core must not fetch (low only in DONE)
//   o_done, o_err         sticky load result until next i_start or reset
//
// Optional feature: define INSTR_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte over all data bytes before DONE.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_valid,
    input  logic [7:0]        i_byte,
    output logic              o_ready,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [31:0]       o_wdata,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_err
);

    state_e                 state_q, state_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [ADDR_W:0]        wcnt_q, wcnt_d;     // words written so far
    logic [ADDR_W-1:0]      waddr_q, waddr_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WORD_W-1:0]      wdata_q, wdata_d;
    logic                   ready_q, we_q, done_q, err_q, hold_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]             xor_q, xor_d;
`endif

    logic                   accept;
    logic                   start_load;
    logic                   last_word;
    logic [LEN_W-1:0]       len_new;
    logic [ADDR_W:0]        wcnt_inc;

    assign accept     = i_valid && ready_q;
    assign start_load = i_start && (state_q == StIdle || state_q == StDone || state_q == StErr);
    assign len_new    = {i_byte, len_q[7:0]};
    assign wcnt_inc   = wcnt_q + 1'b1;
    // Counter is one bit wider than the address so N == DEPTH compares correctly.
    assign last_word  = (32'(wcnt_inc) == 32'(len_q));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        waddr_d = waddr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
`endif

        case (state_q)
            StLenLo: begin
                if (accept) begin
                    len_d   = {len_q[LEN_W-1:8], i_byte};
                    state_d = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d = len_new;
                    if (len_new == '0 || 32'(len_new) > DEPTH) begin
                        state_d = StErr;
                    end else begin
                        wcnt_d  = '0;
                        idx_d   = '0;
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    wdata_d[8*idx_q +: 8] = i_byte;
                    idx_d                 = idx_q + 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    xor_d                 = xor_q ^ i_byte;
`endif
                    if (idx_q == IDX_W'(BYTES_PER_WORD - 1)) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                wcnt_d = wcnt_inc;
                if (last_word) begin
                    // Address is left on the last word so N == DEPTH never wraps to 0.
`ifdef INSTR_LOADER_CHECKSUM_EN
                    state_d = StChk;
`else
                    state_d = StDone;
`endif
                end else begin
                    waddr_d = waddr_q + 1'b1;
                    state_d = StData;
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            StChk: begin
                if (accept) begin
                    state_d = (i_byte == xor_q) ? StDone : StErr;
                end
            end
`endif
            StIdle, StDone, StErr: ;
            default: state_d = StIdle;
        endcase

        if (start_load) begin
            state_d = StLenLo;
            wcnt_d  = '0;
            waddr_d = '0;
            idx_d   = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_d   = '0;
`endif
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            wcnt_q  <= '0;
            waddr_q <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            waddr_q <= waddr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            ready_q <= (state_d == StLenLo) || (state_d == StLenHi) || (state_d == StData)
                       || (state_d == StChk);
            we_q    <= (state_d == StWrite);
            done_q  <= (state_d == StDone);
            err_q   <= (state_d == StErr);
            hold_q  <= (state_d != StDone);
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign o_ready    = ready_q;
    assign o_we       = we_q;
    assign o_waddr    = waddr_q;
    assign o_wdata    = wdata_q;
    assign o_cpu_hold = hold_q;
    assign o_done     = done_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed streams from the block's
// behaviour description plus randomized images checked against a byte-level model.
module tb_instr_loader;

    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned ADDR_W = 12;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b0;
    logic              i_start = 1'b0;
    logic              i_valid = 1'b0;
    logic [7:0]        i_byte = 8'h00;
    logic              o_ready;
    logic              o_we;
    logic [ADDR_W-1:0] o_waddr;
    logic [31:0]       o_wdata;
    logic              o_cpu_hold;
    logic              o_done;
    logic              o_err;

    instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_valid    (i_valid),
        .i_byte     (i_byte),
        .o_ready    (o_ready),
        .o_we       (o_we),
        .o_waddr    (o_waddr),
        .o_wdata    (o_wdata),
        .o_cpu_hold (o_cpu_hold),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]        stream[$];
    logic [31:0]       exp_words[$];
    logic [ADDR_W-1:0] mon_addr[$];
    logic [31:0]       mon_data[$];
    bit                watch_en = 1'b0;
    int                zero_seen = 0;

    // Write monitor, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (watch_en && mon_addr.size() > 0 && o_waddr == '0) zero_seen++;
        if (o_we) begin
            mon_addr.push_back(o_waddr);
            mon_data.push_back(o_wdata);
        end
    end

    // Reference model: words from the stream bytes, little-endian, by arithmetic.
    task automatic model_words();
        int n;
        exp_words.delete();
        n = int'(stream[0]) + 256 * int'(stream[1]);
        if (n == 0 || n > int'(DEPTH)) return;
        for (int i = 0; i < n; i++) begin
            exp_words.push_back(32'(stream[2 + 4*i])
                                + 32'(stream[3 + 4*i]) * 32'h100
                                + 32'(stream[4 + 4*i]) * 32'h10000
                                + 32'(stream[5 + 4*i]) * 32'h1000000);
        end
    endtask

    // Append trailing checksum byte when that feature is built in.
    task automatic add_checksum();
`ifdef INSTR_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 2; i < stream.size(); i++) x = x ^ stream[i];
        stream.push_back(x);
`endif
    endtask

    task automatic build_random(input int n);
        stream.delete();
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        for (int i = 0; i < 4*n; i++) stream.push_back(8'($urandom));
        model_words();
        add_checksum();
    endtask

    task automatic pulse_start();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Offer one byte; returns at the negedge after the accepting posedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        i_valid = 1'b0;
        repeat (gap) @(negedge i_clk);
        i_valid = 1'b1;
        i_byte  = b;
        t = 0;
        while (!o_ready && t < 50) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_accept_timeout: o_ready stayed %b, required 1", o_ready);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic send_stream(input int gap_lo, input int gap_hi);
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i], $urandom_range(gap_hi, gap_lo));
        end
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!o_done && !o_err && t < 20) begin
            @(negedge i_clk);
            t++;
        end
    endtask

    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
    endtask

    task automatic test_reset();
        #2 i_reset = 1'b1;
        #1;
        n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", o_ready); end
        n_cmp++; if (o_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", o_we); end
        n_cmp++; if (o_waddr !== '0) begin n_bad++; $display("FAIL reset_waddr: got %h want 0", o_waddr); end
        n_cmp++; if (o_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", o_wdata); end
        n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", o_done); end
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", o_err); end
        n_cmp++; if (o_cpu_hold !== 1'b1) begin n_bad++; $display("FAIL reset_hold: got %b want 1", o_cpu_hold); end
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_basic(input int gap);
        logic [7:0] s[10];
        s = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h13, 8'h00, 8'h00, 8'h00};
        stream.delete();
        foreach (s[i]) stream.push_back(s[i]);
        add_checksum();
        clear_mon();
        pulse_start();
        n_cmp++; if (o_ready !== 1'b1 || o_done !== 1'b0) begin n_bad++;
            $display("FAIL start_ready: ready=%b done=%b want 1/0", o_ready, o_done); end
        send_stream(gap, gap);
`ifndef INSTR_LOADER_CHECKSUM_EN
        n_cmp++; if (o_we !== 1'b1 || o_done !== 1'b0) begin n_bad++;
            $display("FAIL last_write_cycle: we=%b done=%b want 1/0", o_we, o_done); end
        @(negedge i_clk);
`endif
        n_cmp++; if (o_done !== 1'b1 || o_cpu_hold !== 1'b0 || o_we !== 1'b0) begin n_bad++;
            $display("FAIL done_timing: done=%b hold=%b we=%b want 1/0/0", o_done, o_cpu_hold, o_we); end
        n_cmp++; if (mon_addr.size() !== 2) begin n_bad++;
            $display("FAIL basic_write_count: got %0d want 2", mon_addr.size()); end
        if (mon_addr.size() == 2) begin
            n_cmp++; if (mon_addr[0] !== 12'd0 || mon_data[0] !== 32'hDEADBEEF) begin n_bad++;
                $display("FAIL basic_word0: got %h@%h want deadbeef@000", mon_data[0], mon_addr[0]); end
            n_cmp++; if (mon_addr[1] !== 12'd1 || mon_data[1] !== 32'h00000013) begin n_bad++;
                $display("FAIL basic_word1: got %h@%h want 00000013@001", mon_data[1], mon_addr[1]); end
        end
        n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL done_ready: got %b want 0", o_ready); end
    endtask

    task automatic test_len_err(input logic [7:0] lo, input logic [7:0] hi);
        clear_mon();
        pulse_start();
        n_cmp++; if (o_done !== 1'b0 || o_cpu_hold !== 1'b1) begin n_bad++;
            $display("FAIL restart_clear: done=%b hold=%b want 0/1", o_done, o_cpu_hold); end
        send_byte(lo, 0);
        send_byte(hi, 0);
        repeat (3) @(negedge i_clk);
        n_cmp++; if (o_err !== 1'b1 || o_cpu_hold !== 1'b1 || o_ready !== 1'b0) begin n_bad++;
            $display("FAIL len_err_%h%h: err=%b hold=%b ready=%b want 1/1/0", hi, lo, o_err, o_cpu_hold, o_ready); end
        n_cmp++; if (mon_addr.size() !== 0) begin n_bad++;
            $display("FAIL len_err_we_%h%h: got %0d writes want 0", hi, lo, mon_addr.size()); end
    endtask

    // Compare the captured writes and final status against the model.
    task automatic test_random(input int iters);
        for (int k = 0; k < iters; k++) begin
            build_random($urandom_range(6, 1));
            clear_mon();
            pulse_start();
            if (k == 1) begin
                // i_start pulses mid-load must be ignored.
                for (int i = 0; i < 5; i++) send_byte(stream[i], 0);
                pulse_start();
                for (int i = 5; i < stream.size(); i++) send_byte(stream[i], $urandom_range(2, 0));
            end else begin
                send_stream(0, 2);
            end
            wait_end();
            n_cmp++; if (o_done !== 1'b1 || o_err !== 1'b0) begin n_bad++;
                $display("FAIL rand%0d_status: done=%b err=%b want 1/0", k, o_done, o_err); end
            n_cmp++; if (mon_addr.size() !== exp_words.size()) begin n_bad++;
                $display("FAIL rand%0d_count: got %0d want %0d", k, mon_addr.size(), exp_words.size()); end
            for (int i = 0; i < exp_words.size() && i < mon_addr.size(); i++) begin
                n_cmp++;
                if (mon_addr[i] !== ADDR_W'(i) || mon_data[i] !== exp_words[i]) begin n_bad++;
                    $display("FAIL rand%0d_word%0d: got %h@%h want %h@%h", k, i, mon_data[i],
                             mon_addr[i], exp_words[i], ADDR_W'(i)); end
            end
        end
    endtask

    task automatic test_reset_mid();
        build_random(2);
        clear_mon();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(stream[i], 0);
        #2 i_reset = 1'b1;
        #1;
        n_cmp++; if (o_ready !== 1'b0 || o_cpu_hold !== 1'b1 || o_waddr !== '0 || o_wdata !== 32'h0)
            begin n_bad++; $display("FAIL reset_mid: ready=%b hold=%b waddr=%h wdata=%h want 0/1/0/0",
                                    o_ready, o_cpu_hold, o_waddr, o_wdata); end
        @(negedge i_clk);
        i_reset = 1'b0;
        clear_mon();
        pulse_start();
        send_stream(0, 1);
        wait_end();
        n_cmp++; if (o_done !== 1'b1 || mon_addr.size() !== 2) begin n_bad++;
            $display("FAIL reset_mid_reload: done=%b writes=%0d want 1/2", o_done, mon_addr.size()); end
        if (mon_addr.size() == 2) begin
            n_cmp++; if (mon_data[0] !== exp_words[0] || mon_data[1] !== exp_words[1]) begin n_bad++;
                $display("FAIL reset_mid_data: got %h %h want %h %h", mon_data[0], mon_data[1],
                         exp_words[0], exp_words[1]); end
        end
    endtask

    task automatic test_full_depth();
        int bad;
        build_random(int'(DEPTH));
        clear_mon();
        pulse_start();
        zero_seen = 0;
        watch_en  = 1'b1;
        send_stream(0, 0);
        wait_end();
        repeat (3) @(negedge i_clk);
        watch_en = 1'b0;
        n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL full_done: got %b want 1", o_done); end
        n_cmp++; if (mon_addr.size() !== int'(DEPTH)) begin n_bad++;
            $display("FAIL full_count: got %0d want %0d", mon_addr.size(), DEPTH); end
        n_cmp++; if (mon_addr.size() > 0 && mon_addr[mon_addr.size()-1] !== 12'hFFF) begin n_bad++;
            $display("FAIL full_last_addr: got %h want fff", mon_addr[mon_addr.size()-1]); end
        n_cmp++; if (zero_seen !== 0) begin n_bad++;
            $display("FAIL full_no_wrap: waddr zero seen %0d times want 0", zero_seen); end
        bad = 0;
        for (int i = 0; i < mon_addr.size() && i < exp_words.size(); i++) begin
            if (mon_addr[i] !== ADDR_W'(i) || mon_data[i] !== exp_words[i]) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++;
            $display("FAIL full_words: %0d words wrong want 0", bad); end
    endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
    task automatic test_checksum(input logic [7:0] chk, input bit good);
        logic [7:0] s[7];
        s = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
        s[6] = chk;
        stream.delete();
        foreach (s[i]) stream.push_back(s[i]);
        clear_mon();
        pulse_start();
        send_stream(0, 1);
        wait_end();
        n_cmp++; if (o_done !== good || o_err !== !good || o_cpu_hold !== !good) begin n_bad++;
            $display("FAIL chk_%h: done=%b err=%b hold=%b want %b/%b/%b", chk, o_done, o_err,
                     o_cpu_hold, good, !good, !good); end
        n_cmp++; if (mon_addr.size() !== 1 || mon_data[0] !== 32'h11223344) begin n_bad++;
            $display("FAIL chk_word_%h: writes=%0d want 1 of 11223344", chk, mon_addr.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic(0);
        test_basic(1);
        test_len_err(8'h00, 8'h00);
        test_len_err(8'h01, 8'h10);
        test_random(6);
        test_reset_mid();
        test_full_depth();
`ifdef INSTR_LOADER_CHECKSUM_EN
        test_checksum(8'h44, 1'b1);
        test_checksum(8'h00, 1'b0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time writer for the instruction memory of the pipelined core.
- Receives a byte stream on a valid/ready interface, typically from a UART receiver or testbench.
- Assembles little-endian 32-bit instructions and drives a word-addressed write port into instruction memory.
- Holds the core in stall until the full image is written.

Parameters:
- DEPTH, 4096, instruction memory depth in 32-bit words.
- ADDR_W, 12, word-address width; must equal clog2(DEPTH).

Ports:
- i_clk  input  1  single clock.
- i_reset  input  1  asynchronous reset, active-high.
- i_start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- i_valid  input  1  byte available on i_byte.
- i_byte  input  8  stream byte.
- o_ready  output  1  loader accepts a byte this cycle.
- o_we  output  1  instruction memory write enable, one-cycle pulse per word.
- o_waddr  output  ADDR_W  word address of the write.
- o_wdata  output  32  instruction word.
- o_cpu_hold  output  1  high while the core must not fetch.
- o_done  output  1  image loaded successfully; stays high until the next i_start or reset.
- o_err  output  1  load aborted; stays high until the next i_start or reset.

Behaviour:
- Reset values (reset asserted, asynchronous):
  - o_ready=0, o_we=0, o_waddr=0, o_wdata=0, o_done=0, o_err=0, o_cpu_hold=1.
  - FSM enters IDLE; all counters are cleared.
- Byte handshake: a byte is accepted on a rising edge where i_valid && o_ready.
- o_ready is registered and is high only in LEN_LO, LEN_HI and DATA (also CHK when enabled).
- Stream format:
  - 16-bit word count N, low byte first.
  - Then N words, each sent as 4 bytes, least-significant byte first.
- FSM transitions:
  - IDLE -> LEN_LO on i_start.
  - LEN_LO -> LEN_HI on byte accept; the byte is stored as len[7:0].
  - LEN_HI -> on byte accept, with len[15:8] = byte:
    - if N==0 or N>DEPTH, go to ERR;
    - otherwise clear the word counter and byte index, and go to DATA.
  - DATA: each accepted byte is written into o_wdata[8*idx +: 8]; idx (2 bits) increments.
    - On accepting the byte with idx==3, go to WRITE.
  - WRITE (exactly 1 cycle):
    - o_we=1 with o_waddr = current word count and o_wdata = the assembled word; o_ready=0.
    - On exit, o_waddr increments.
    - If the written word was number N (last), go to DONE (or CHK when enabled); else go back to DATA.
  - DONE: o_done=1, o_cpu_hold=0, o_ready=0.
  - ERR: o_err=1, o_cpu_hold=1, o_ready=0.
- o_cpu_hold is 1 in every state except DONE.
- Latency: o_we rises the cycle after the 4th byte of a word is accepted.
  - Minimum 5 cycles per word; minimum image time is 2 + 5N cycles after i_start.
- Boundary cases:
  - i_start while in LEN_LO/LEN_HI/DATA/WRITE is ignored.
  - i_start in DONE or ERR clears o_done/o_err, sets o_cpu_hold=1, zeroes o_waddr, and enters LEN_LO.
  - i_valid with o_ready=0 is ignored; no byte is consumed.
  - N==DEPTH is legal: the last o_waddr is DEPTH-1, and no wrap-around write occurs.
  - Reset mid-load returns to IDLE immediately; partially written memory content is not cleared.
- Counters are unsigned, ADDR_W+1 bits wide so that N==DEPTH compares correctly.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- With the macro defined:
  - After the last WRITE, the FSM enters CHK, which accepts one byte.
  - The byte must equal the XOR of all 4N data bytes (a running XOR, cleared on entry to LEN_LO).
  - Match goes to DONE; mismatch goes to ERR.
- Without the macro: no CHK state and no XOR register; the last WRITE goes straight to DONE.

Decomposition:
- Shared package instr_loader_pkg holds:
  - the state enum (IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHK, DONE, ERR);
  - localparam LEN_BYTES=2 and BYTES_PER_WORD=4.
- No sub-module; the byte assembler and FSM are a single block.

Test Plan:
- Reset mid-DATA (after 2 bytes of word 0) -> outputs return to reset values asynchronously; a following i_start plus a full stream loads correctly.
- i_start, stream 02 00, then EF BE AD DE, 13 00 00 00, with i_valid held high ->
  - o_we pulses twice: addr 0 data DEADBEEF, then addr 1 data 00000013;
  - o_done=1 and o_cpu_hold=0 one cycle after the second write.
- Same stream with i_valid toggling every other cycle -> identical writes and data, later completion, no dropped or duplicated bytes.
- Length 00 00 -> o_err=1, o_we never asserted. Length 01 10 (4097) with DEPTH=4096 -> o_err=1.
- N=DEPTH stream -> last write at o_waddr=4095, then o_done; o_waddr is never seen at 0 after the first write.
- With INSTR_LOADER_CHECKSUM_EN, N=1, word 11223344 ->
  - trailing byte 44 (XOR of 44,33,22,11) gives o_done;
  - trailing byte 00 gives o_err with o_cpu_hold=1.
